// File: rtl/regfile_pkg.sv
// Shared types, default sizes and port-slicing helper for the multi-port register file.
package regfile_pkg;
   typedef enum logic {CLEAR, RUN} rf_state_e;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int NUM_RD_DEF = 2;

   // Base bit of port k inside a flattened bus of w-bit fields.
   function automatic int rd_slice(input int k, input int w = DATA_W_DEF);
      return k * w;
   endfunction
endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks idx 1..DEPTH-1 writing zeros, then raises ready.
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              ready
);
   rf_state_e         state_q;
   logic [ADDR_W-1:0] idx_q;
   logic              ready_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR;
         idx_q   <= ADDR_W'(1);
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            CLEAR: begin
               idx_q <= idx_q + ADDR_W'(1);
               if (idx_q == {ADDR_W{1'b1}}) begin
                  state_q <= RUN;
                  ready_q <= 1'b1;
               end
            end
            RUN: ;
            default: state_q <= CLEAR;
         endcase
      end
   end

   assign clr_we   = (state_q == CLEAR);
   assign clr_addr = idx_q;
   assign ready    = ready_q;
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (port 1 wins), NUM_RD read ports with
// optional write bypass, pending scoreboard mask and a debug read tap.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NUM_RD = NUM_RD_DEF,
   parameter int BYPASS = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     ready,
   input  logic [NUM_RD*ADDR_W-1:0] ra,
   output logic [NUM_RD*DATA_W-1:0] rd,
   input  logic                     we0,
   input  logic [ADDR_W-1:0]        wa0,
   input  logic [DATA_W-1:0]        wd0,
   input  logic                     we1,
   input  logic [ADDR_W-1:0]        wa1,
   input  logic [DATA_W-1:0]        wd1,
   input  logic                     pend_set,
   input  logic [ADDR_W-1:0]        pend_addr,
   output logic [(2**ADDR_W)-1:0]   pend_q,
   input  logic [ADDR_W-1:0]        dbg_sel,
   output logic [DATA_W-1:0]        dbg_data
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] rf_q [DEPTH];
   logic [DEPTH-1:0]  pend_d;
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              run;
   logic              wr0_ok, wr1_ok;

   regfile_clear_seq #(.ADDR_W(ADDR_W)) u_seq (
      .clk      (clk),
      .rst      (rst),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .ready    (ready)
   );

   assign run    = ready & ~rst;
   assign wr1_ok = run & we1 & (wa1 != '0);
   // Port 0 backs off on an address collision so only wd1 lands.
   assign wr0_ok = run & we0 & (wa0 != '0) & ~(we1 & (wa1 == wa0));

   always_ff @(posedge clk) begin
      if (clr_we) begin
         rf_q[clr_addr] <= '0;
      end else begin
         if (wr0_ok) rf_q[wa0] <= wd0;
         if (wr1_ok) rf_q[wa1] <= wd1;
      end
   end

   // Clear on writeback first, then set, so a newly issued producer wins.
   always_comb begin
      pend_d = pend_q;
      if (run) begin
         if (we0)      pend_d[wa0]       = 1'b0;
         if (we1)      pend_d[wa1]       = 1'b0;
         if (pend_set) pend_d[pend_addr] = 1'b1;
      end
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) pend_q <= '0;
      else     pend_q <= pend_d;
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] v;
      assign a = ra[rd_slice(k, ADDR_W) +: ADDR_W];
      always_comb begin
         v = rf_q[a];
         if (BYPASS != 0) begin
            if (run && we1 && wa1 == a)      v = wd1;
            else if (run && we0 && wa0 == a) v = wd0;
         end
         if (!ready || a == '0) v = '0;
      end
      assign rd[rd_slice(k, DATA_W) +: DATA_W] = v;
   end

   assign dbg_data = (!ready || dbg_sel == '0) ? '0 : rf_q[dbg_sel];
endmodule
